result_bcd_conv: RTL and testbench
==================================

Name: result_bcd_conv

Overview:
- Sequential double-dabble converter between the calculator's result/sign/valid registers and the seven-segment driver.
- Takes the latched 8-bit result, optional two's-complement interpretation and validity flag. Produces packed BCD digits, a negative flag and an error flag for display.
- Converts one bit per clock under a start/busy/done handshake. Output digits are held stable between conversions so the display never shows partial values.

Parameters:
- WIDTH, 8, bit width of the binary input value.
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- value  input  WIDTH  binary result to convert
- sgd  input  1  1 = value is two's complement, 0 = unsigned
- valid  input  1  1 = result is valid, 0 = overflow/invalid
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd/neg/err are updated
- bcd  output  4*DIGITS  packed BCD; digit 0 in bits [3:0]
- neg  output  1  result is negative (signed mode only)
- err  output  1  last request had valid=0

Behaviour:
- Reset (async, immediate):
  - state=IDLE; busy=0, done=0, neg=0, err=0.
  - bcd = all zero digits; shift and count registers cleared.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - If start=1 and valid=1 at edge N: capture value/sgd; go to SHIFT; busy=1 from N+1.
  - Magnitude rule: if sgd=1 and value[WIDTH-1]=1, magnitude = two's-complement negation and neg_next=1. Otherwise magnitude = value and neg_next=0.
  - Width rule: the magnitude register is WIDTH bits, unsigned, so -128 gives magnitude 128 with no overflow.
  - If start=1 and valid=0 at edge N: go to FIN directly; err_next=1; bcd_next = all digits 4'hF (display blank/dash code).
- SHIFT:
  - Each cycle, every BCD digit >= 5 gets +3. Then the combined {bcd_work, magnitude} register shifts left by 1.
  - The iteration counter runs 0..WIDTH-1. After WIDTH shifts, go to FIN.
- FIN (one cycle):
  - bcd, neg, err take their new values; done=1; busy=0 next cycle; return to IDLE.
  - err is cleared on any valid conversion.
- Latency:
  - Valid request: start at edge N, done at N+WIDTH+1 (N+9 for WIDTH=8); busy high N+1..N+WIDTH+1.
  - Invalid request: done at N+1.
- Handshake and hold rules:
  - start while busy is ignored, with no queuing.
  - start held high re-triggers immediately after returning to IDLE.
  - Outputs change only on the done cycle.
- Reset asserted mid-conversion: abort immediately. Outputs take reset values, not the stale previous result.
- Input changes after the capture edge have no effect on the conversion in flight.

Optional Feature:
- Macro: RESULT_BCD_ZERO_BLANK_EN.
- Defined: at FIN, leading zero digits (most significant downward) are replaced with 4'hF. Digit 0 is never blanked, so value 0 shows as F,F,0 and 7 shows as F,F,7. The error encoding is unaffected.
- Undefined: digits are emitted raw, including leading zeros (7 gives 0,0,7).

Decomposition:
- Shared package result_bcd_pkg:
  - state enum (IDLE, SHIFT, FIN);
  - localparam BCD_BLANK = 4'hF;
  - function for the digit-count check.
- One sub-module, bcd_digit_adj: 4-bit combinational add-3-if->=5 cell, instantiated DIGITS times by generate.

Test Plan:
- Unsigned, valid: value=8'd255, sgd=0, start pulse -> done exactly 9 cycles later; bcd=12'h255, neg=0, err=0.
- Signed negative: value=8'h80, sgd=1 -> bcd=12'h128, neg=1. Then value=8'hFF, sgd=1 -> bcd=12'h001 (raw) / 12'hFF1 (blank), neg=1.
- Invalid request: valid=0, value=8'd42, start -> done 1 cycle later; bcd=12'hFFF, err=1. A following valid conversion of 8'd42 clears err; bcd=12'h042 (raw) / 12'hF42 (blank).
- Busy and hold: start held high with value changed mid-conversion from 8'd99 to 8'd13 -> first done gives 12'h099. Back-to-back second conversion then gives 12'h013. bcd stays stable between done pulses.
- Reset mid-operation: assert reset 4 cycles into a conversion of 8'd200 -> busy=0, done=0, bcd=0, neg=0 immediately (asynchronous, before the next clock edge). No done pulse follows reset release.
- Zero: value=0, sgd=1 -> bcd=12'h000 (raw) / 12'hFF0 (blank), neg=0.

Source files
------------

// File: rtl/result_bcd_conv_pkg.sv
// Shared types and constants for the result-to-BCD converter.
package result_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
    function automatic bit digits_fit(input int width, input int digits);
        longint p10;
        longint p2;
        p10 = 1;
        p2  = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        for (int i = 0; i < width; i++) p2 = p2 * 2;
        return p10 > p2;
    endfunction

endpackage

// File: rtl/result_bcd_conv_if.sv
// Handshake and data bundle between the result registers and the BCD converter.
interface result_bcd_conv_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  sgd;
    logic                  valid;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  err;

    modport master (
        output start, value, sgd, valid,
        input  busy, done, bcd, neg, err
    );

    modport slave (
        input  start, value, sgd, valid,
        output busy, done, bcd, neg, err
    );
endinterface

// File: rtl/result_bcd_conv_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/result_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking when RESULT_BCD_ZERO_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SHIFT | one adjust+shift per clock, WIDTH cycles
// FIN   | done pulse; new bcd/neg/err visible this cycle
module result_bcd_conv
    import result_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    result_bcd_conv_if.slave   bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_cfg
        $error("result_bcd_conv: DIGITS too small for WIDTH");
    end

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_work, bcd_work_nxt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [WIDTH-1:0]   mag, mag_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               neg_work, neg_work_nxt;
    logic [BCD_W-1:0]   bcd_out, bcd_out_nxt;
    logic               neg_out, neg_out_nxt;
    logic               err_out, err_out_nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_work[4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    function automatic logic [BCD_W-1:0] fmt_digits(input logic [BCD_W-1:0] d);
`ifdef RESULT_BCD_ZERO_BLANK_EN
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = d;
        lead = 1'b1;
        // Digit 0 is never blanked so a zero result still shows a 0.
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && d[4*i +: 4] == 4'd0) r[4*i +: 4] = BCD_BLANK;
            else                             lead = 1'b0;
        end
        return r;
`else
        return d;
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bcd_work <= '0;
            mag      <= '0;
            cnt      <= '0;
            neg_work <= 1'b0;
            bcd_out  <= '0;
            neg_out  <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bcd_work <= bcd_work_nxt;
            mag      <= mag_nxt;
            cnt      <= cnt_nxt;
            neg_work <= neg_work_nxt;
            bcd_out  <= bcd_out_nxt;
            neg_out  <= neg_out_nxt;
            err_out  <= err_out_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bcd_work_nxt = bcd_work;
        mag_nxt      = mag;
        cnt_nxt      = cnt;
        neg_work_nxt = neg_work;
        bcd_out_nxt  = bcd_out;
        neg_out_nxt  = neg_out;
        err_out_nxt  = err_out;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.valid) begin
                        state_nxt    = SHIFT;
                        bcd_work_nxt = '0;
                        cnt_nxt      = '0;
                        // Magnitude is unsigned WIDTH bits, so the most negative value negates cleanly.
                        if (bus.sgd && bus.value[WIDTH-1]) begin
                            mag_nxt      = ~bus.value + 1'b1;
                            neg_work_nxt = 1'b1;
                        end else begin
                            mag_nxt      = bus.value;
                            neg_work_nxt = 1'b0;
                        end
                    end else begin
                        state_nxt   = FIN;
                        bcd_out_nxt = {DIGITS{BCD_BLANK}};
                        neg_out_nxt = 1'b0;
                        err_out_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                {bcd_work_nxt, mag_nxt} = {bcd_adj, mag} << 1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt   = FIN;
                    bcd_out_nxt = fmt_digits(bcd_work_nxt);
                    neg_out_nxt = neg_work;
                    err_out_nxt = 1'b0;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FIN);
    assign bus.bcd  = bcd_out;
    assign bus.neg  = neg_out;
    assign bus.err  = err_out;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Directed bench for result_bcd_conv: latency, signed/unsigned, invalid, hold and reset cases.
module tb_result_bcd_conv;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

`ifdef RESULT_BCD_ZERO_BLANK_EN
    localparam logic [11:0] EXP_M1 = 12'hFF1;
    localparam logic [11:0] EXP_42 = 12'hF42;
    localparam logic [11:0] EXP_99 = 12'hF99;
    localparam logic [11:0] EXP_13 = 12'hF13;
    localparam logic [11:0] EXP_0  = 12'hFF0;
`else
    localparam logic [11:0] EXP_M1 = 12'h001;
    localparam logic [11:0] EXP_42 = 12'h042;
    localparam logic [11:0] EXP_99 = 12'h099;
    localparam logic [11:0] EXP_13 = 12'h013;
    localparam logic [11:0] EXP_0  = 12'h000;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    result_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    result_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge and returns the cycle count until done is seen.
    task automatic convert(input logic [7:0] v, input logic s, input logic vl, output int lat);
        bus.value = v;
        bus.sgd   = s;
        bus.valid = vl;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_rise", {31'd0, bus.busy}, 32'd1);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic after_done();
        tick();
        check("done_pulse", {31'd0, bus.done}, 32'd0);
        check("busy_fall", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int unstable;
        int done_seen;

        bus.start = 1'b0;
        bus.value = '0;
        bus.sgd   = 1'b0;
        bus.valid = 1'b1;

        #3;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bcd",  {20'd0, bus.bcd},  32'd0);
        check("rst_neg",  {31'd0, bus.neg},  32'd0);
        check("rst_err",  {31'd0, bus.err},  32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        convert(8'd255, 1'b0, 1'b1, lat);
        check("u255_lat",  lat, 32'd9);
        check("u255_busy", {31'd0, bus.busy}, 32'd1);
        check("u255_bcd",  {20'd0, bus.bcd}, 32'h255);
        check("u255_neg",  {31'd0, bus.neg}, 32'd0);
        check("u255_err",  {31'd0, bus.err}, 32'd0);
        after_done();
        check("u255_hold", {20'd0, bus.bcd}, 32'h255);

        convert(8'h80, 1'b1, 1'b1, lat);
        check("s80_lat", lat, 32'd9);
        check("s80_bcd", {20'd0, bus.bcd}, 32'h128);
        check("s80_neg", {31'd0, bus.neg}, 32'd1);
        after_done();

        convert(8'hFF, 1'b1, 1'b1, lat);
        check("sff_lat", lat, 32'd9);
        check("sff_bcd", {20'd0, bus.bcd}, {20'd0, EXP_M1});
        check("sff_neg", {31'd0, bus.neg}, 32'd1);
        after_done();

        // Reset four cycles into a conversion of 200.
        bus.value = 8'd200;
        bus.sgd   = 1'b0;
        bus.valid = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_bcd",  {20'd0, bus.bcd},  32'd0);
        check("arst_neg",  {31'd0, bus.neg},  32'd0);
        tick();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
        end
        check("arst_no_done", done_seen, 32'd0);
        check("arst_bcd_kept", {20'd0, bus.bcd}, 32'd0);

        convert(8'd42, 1'b0, 1'b0, lat);
        check("inv_lat", lat, 32'd1);
        check("inv_bcd", {20'd0, bus.bcd}, 32'hFFF);
        check("inv_err", {31'd0, bus.err}, 32'd1);
        after_done();
        check("inv_err_hold", {31'd0, bus.err}, 32'd1);

        convert(8'd42, 1'b0, 1'b1, lat);
        check("v42_lat", lat, 32'd9);
        check("v42_bcd", {20'd0, bus.bcd}, {20'd0, EXP_42});
        check("v42_err", {31'd0, bus.err}, 32'd0);
        after_done();

        // start held high; value changes mid-flight and must not disturb the first result.
        bus.value = 8'd99;
        bus.sgd   = 1'b0;
        bus.valid = 1'b1;
        bus.start = 1'b1;
        tick();
        lat = 1;
        tick();
        tick();
        tick();
        lat = 4;
        bus.value = 8'd13;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("hold_lat1", lat, 32'd9);
        check("hold_bcd1", {20'd0, bus.bcd}, {20'd0, EXP_99});
        lat = 0;
        unstable = 0;
        do begin
            tick();
            lat++;
            if (bus.done !== 1'b1 && bus.bcd !== EXP_99) unstable++;
        end while (bus.done !== 1'b1 && lat < 40);
        check("hold_lat2", lat, 32'd10);
        check("hold_stable", unstable, 32'd0);
        check("hold_bcd2", {20'd0, bus.bcd}, {20'd0, EXP_13});
        bus.start = 1'b0;
        tick();
        tick();
        check("hold_idle", {31'd0, bus.busy}, 32'd0);

        convert(8'd0, 1'b1, 1'b1, lat);
        check("zero_lat", lat, 32'd9);
        check("zero_bcd", {20'd0, bus.bcd}, {20'd0, EXP_0});
        check("zero_neg", {31'd0, bus.neg}, 32'd0);
        after_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
